// File: rtl/button_event.sv
// button_event: turns a debounced button level into press/release/long-press/repeat pulses.
module button_event #(
  parameter int unsigned LONG_CYCLES   = 1000,
  parameter int unsigned REPEAT_CYCLES = 250,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_i,
  input  logic       enable_i,
  output logic       press_o,
  output logic       release_o,
  output logic       long_press_o,
  output logic       repeat_o,
  output logic       held_o,
  output logic [7:0] press_count_o
);
  typedef enum logic [1:0] {IDLE, PRESSED, REPEAT} state_t;
  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_CYCLES - 1);
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_q;
  logic             rise;
  logic             fall;
  logic             at_tc;
  assign rise  = in_i & ~in_q;
  assign fall  = ~in_i & in_q;
  assign at_tc = cnt_q == ((state_q == PRESSED) ? LONG_TC : REP_TC);
  // in_q loads the live level in reset so a button held through reset never looks like a new press
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      in_q          <= in_i;
      press_o       <= 1'b0;
      release_o     <= 1'b0;
      long_press_o  <= 1'b0;
      repeat_o      <= 1'b0;
      held_o        <= 1'b0;
      press_count_o <= 8'd0;
    end else begin
      in_q         <= in_i;
      press_o      <= 1'b0;
      release_o    <= 1'b0;
      long_press_o <= 1'b0;
      repeat_o     <= 1'b0;
      case (state_q)
        IDLE: if (rise && enable_i) begin
          press_o       <= 1'b1;
          press_count_o <= press_count_o + 8'd1;
          cnt_q         <= '0;
          state_q       <= PRESSED;
          held_o        <= 1'b1;
        end
        PRESSED, REPEAT: if (!enable_i || fall) begin
          release_o <= enable_i;
          cnt_q     <= '0;
          state_q   <= IDLE;
          held_o    <= 1'b0;
        end else if (at_tc) begin
          cnt_q        <= '0;
          long_press_o <= state_q == PRESSED;
          repeat_o     <= state_q == REPEAT;
          state_q      <= REPEAT;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          held_o  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_button_event.sv
// tb_button_event: directed scenario checks of button_event with LONG_CYCLES=8, REPEAT_CYCLES=4.
module tb_button_event;
  logic clk = 1'b0, reset = 1'b1, in_r = 1'b0, enable_r = 1'b1;
  logic press, rel, lp, rep, held;
  logic [7:0] cnt;
  int passed = 0, total = 0;
  int cyc, press_n, press_at, rel_n, rel_at, lp_n, lp_at, rep_n, rep_first, rep_last, held_n, multi, wide;
  logic pp, pr;

  button_event #(.LONG_CYCLES(8), .REPEAT_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_i(in_r), .enable_i(enable_r),
    .press_o(press), .release_o(rel), .long_press_o(lp), .repeat_o(rep),
    .held_o(held), .press_count_o(cnt)
  );

  always #5 clk = ~clk;

  task automatic clr();
    cyc = 0; press_n = 0; press_at = 0; rel_n = 0; rel_at = 0; lp_n = 0; lp_at = 0;
    rep_n = 0; rep_first = 0; rep_last = 0; held_n = 0; multi = 0; wide = 0; pp = 0; pr = 0;
  endtask

  task automatic run(input int n, input logic v);
    in_r = v;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (press) begin press_n++; press_at = cyc; end
      if (rel) begin rel_n++; rel_at = cyc; end
      if (lp) begin lp_n++; lp_at = cyc; end
      if (rep) begin if (rep_n == 0) rep_first = cyc; rep_n++; rep_last = cyc; end
      if (held) held_n++;
      if (int'(press) + int'(rel) + int'(lp) + int'(rep) > 1) multi++;
      if ((press && pp) || (rel && pr)) wide++;
      pp = press; pr = rel;
    end
  endtask

  task automatic test_reset();
    reset = 1; in_r = 0; enable_r = 1;
    run(2, 0);
    total++; if ({press, rel, lp, rep, held} !== 5'b0) $display("FAIL reset_pulses: got %b want 00000", {press, rel, lp, rep, held}); else passed++;
    total++; if (cnt !== 8'd0) $display("FAIL reset_count: got %0d want 0", cnt); else passed++;
    reset = 0;
    run(2, 0);
  endtask

  task automatic test_short_press();
    clr(); run(3, 1); run(3, 0);
    total++; if (press_n !== 1 || press_at !== 1) $display("FAIL short_press: got n=%0d at=%0d want n=1 at=1", press_n, press_at); else passed++;
    total++; if (rel_n !== 1 || rel_at !== 4) $display("FAIL short_release: got n=%0d at=%0d want n=1 at=4", rel_n, rel_at); else passed++;
    total++; if (lp_n !== 0) $display("FAIL short_long: got %0d want 0", lp_n); else passed++;
    total++; if (held_n !== 3) $display("FAIL short_held: got %0d want 3", held_n); else passed++;
    total++; if (cnt !== 8'd1) $display("FAIL short_count: got %0d want 1", cnt); else passed++;
  endtask

  task automatic test_long_hold();
    clr(); run(20, 1); run(3, 0);
    total++; if (press_n !== 1 || press_at !== 1) $display("FAIL long_press_edge: got n=%0d at=%0d want n=1 at=1", press_n, press_at); else passed++;
    total++; if (lp_n !== 1 || lp_at !== 9) $display("FAIL long_pulse: got n=%0d at=%0d want n=1 at=9", lp_n, lp_at); else passed++;
    total++; if (rep_n !== 2 || rep_first !== 13 || rep_last !== 17) $display("FAIL long_repeat: got n=%0d first=%0d last=%0d want 2/13/17", rep_n, rep_first, rep_last); else passed++;
    total++; if (rel_n !== 1 || rel_at !== 21) $display("FAIL long_release: got n=%0d at=%0d want n=1 at=21", rel_n, rel_at); else passed++;
    total++; if (multi !== 0) $display("FAIL long_exclusive: got %0d overlapping cycles want 0", multi); else passed++;
    total++; if (cnt !== 8'd2) $display("FAIL long_count: got %0d want 2", cnt); else passed++;
  endtask

  task automatic test_collision();
    clr(); run(8, 1); run(3, 0);
    total++; if (rel_n !== 1 || rel_at !== 9) $display("FAIL coll_release: got n=%0d at=%0d want n=1 at=9", rel_n, rel_at); else passed++;
    total++; if (lp_n !== 0) $display("FAIL coll_long: got %0d want 0", lp_n); else passed++;
    total++; if (held !== 1'b0) $display("FAIL coll_idle: got held=%b want 0", held); else passed++;
  endtask

  task automatic test_enable_gating();
    enable_r = 0;
    clr(); run(3, 1);
    enable_r = 1;
    run(3, 1); run(2, 0);
    total++; if (press_n !== 0 || held_n !== 0) $display("FAIL gate_nopress: got press=%0d held=%0d want 0/0", press_n, held_n); else passed++;
    total++; if (cnt !== 8'd3) $display("FAIL gate_count: got %0d want 3", cnt); else passed++;
    clr(); run(10, 1);
    enable_r = 0;
    run(1, 1);
    total++; if (held !== 1'b0) $display("FAIL gate_held_drop: got %b want 0", held); else passed++;
    run(8, 1); run(2, 0);
    total++; if (rel_n !== 0 || rep_n !== 0 || lp_n !== 1) $display("FAIL gate_pulses: got rel=%0d rep=%0d long=%0d want 0/0/1", rel_n, rep_n, lp_n); else passed++;
    enable_r = 1;
    total++; if (cnt !== 8'd4) $display("FAIL gate_count2: got %0d want 4", cnt); else passed++;
  endtask

  task automatic test_reset_mid_hold();
    clr(); run(10, 1);
    reset = 1;
    run(2, 1);
    total++; if ({press, rel, lp, rep, held} !== 5'b0 || cnt !== 8'd0) $display("FAIL midrst_outputs: got %b cnt=%0d want 00000 cnt=0", {press, rel, lp, rep, held}, cnt); else passed++;
    reset = 0;
    clr(); run(5, 1);
    total++; if (press_n !== 0 || held_n !== 0) $display("FAIL midrst_nopress: got press=%0d held=%0d want 0/0", press_n, held_n); else passed++;
    run(2, 0); run(3, 1);
    total++; if (press_n !== 1 || cnt !== 8'd1) $display("FAIL midrst_repress: got press=%0d cnt=%0d want 1/1", press_n, cnt); else passed++;
    run(2, 0);
  endtask

  task automatic test_wrap();
    reset = 1; run(2, 0); reset = 0;
    clr();
    for (int i = 0; i < 255; i++) begin run(1, 1); run(1, 0); end
    total++; if (cnt !== 8'd255) $display("FAIL wrap_255: got %0d want 255", cnt); else passed++;
    run(1, 1); run(1, 0); run(2, 0);
    total++; if (cnt !== 8'd0) $display("FAIL wrap_zero: got %0d want 0", cnt); else passed++;
    total++; if (press_n !== 256 || rel_n !== 256) $display("FAIL wrap_pulses: got press=%0d rel=%0d want 256/256", press_n, rel_n); else passed++;
    total++; if (wide !== 0) $display("FAIL wrap_width: got %0d wide pulses want 0", wide); else passed++;
  endtask

  initial begin
    clr();
    test_reset();
    test_short_press();
    test_long_hold();
    test_collision();
    test_enable_gating();
    test_reset_mid_hold();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
